// File: rtl/wc_pkg.sv
// Shared constants and types for the F(3,5) Winograd convolution front end.
package wc_pkg;

  localparam int WC_DW   = 10;
  localparam int WC_M    = 3;
  localparam int WC_R    = 5;
  localparam int WC_TILE = WC_M + WC_R - 1;

  typedef logic signed [WC_DW-1:0] sample_t;

  typedef enum logic [1:0] {
    FILL,
    STRIDE,
    PAD
  } state_t;

endpackage

// File: rtl/wc_tile_skid.sv
// Single-entry tile holding register.
// Contents are held stable while the consumer stalls.
module wc_tile_skid #(
  parameter int W = 70
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_data,
  input  logic         ld_last,
  input  logic         t_ready,
  output logic         t_valid,
  output logic [W-1:0] t_data,
  output logic         t_last,
  output logic         busy
);

  assign busy = t_valid && !t_ready;

  // The producer only loads while not busy, so a load may overlap a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_valid <= 1'b0;
      t_data  <= '0;
      t_last  <= 1'b0;
    end else if (load) begin
      t_valid <= 1'b1;
      t_data  <= ld_data;
      t_last  <= ld_last;
    end else if (t_ready) begin
      t_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wc_tile_feeder.sv
// Stream-to-tile feeder: overlapping 7-sample tiles, stride 3, zero-padded frame end.
// Define WC_TILE_IDX_EN to add the t_idx tile-index output.
module wc_tile_feeder
  import wc_pkg::*;
#(
  parameter int DW     = WC_DW,
  parameter int TILE   = WC_TILE,
  parameter int STRIDE = WC_M
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  input  logic               s_last,
  output logic               t_valid,
  input  logic               t_ready,
  output logic [TILE*DW-1:0] t_data,
  output logic               t_last
`ifdef WC_TILE_IDX_EN
  ,
  output logic [15:0]        t_idx
`endif
);

  localparam int NW = $clog2(TILE + 1);

  logic [TILE*DW-1:0] win;
  logic [TILE*DW-1:0] win_nxt;
  logic [NW-1:0]      need;
  state_t             state;
  logic [DW-1:0]      shin;
  logic busy;
  logic stall;
  logic acc;
  logic pad_step;
  logic shift;
  logic complete;
  logic closes;

  assign stall    = (need == NW'(1)) && busy;
  assign s_ready  = (state != PAD) && !stall;
  assign acc      = s_valid && s_ready;
  assign pad_step = (state == PAD) && !stall;
  assign shift    = acc || pad_step;
  assign shin     = acc ? s_data : '0;
  assign win_nxt  = {win[(TILE-1)*DW-1:0], shin};
  assign complete = shift && (need == NW'(1));
  assign closes   = pad_step || (acc && s_last);

  // The STRIDE parameter hides the enum literal, hence the scoped name.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      need  <= NW'(TILE);
      win   <= '0;
    end else if (shift) begin
      if (complete && closes) begin
        state <= FILL;
        need  <= NW'(TILE);
        win   <= '0;
      end else if (complete) begin
        state <= wc_pkg::STRIDE;
        need  <= NW'(STRIDE);
        win   <= win_nxt;
      end else begin
        need <= need - NW'(1);
        win  <= win_nxt;
        if (acc && s_last) state <= PAD;
      end
    end
  end

  wc_tile_skid #(
    .W(TILE*DW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (complete),
    .ld_data (win_nxt),
    .ld_last (closes),
    .t_ready (t_ready),
    .t_valid (t_valid),
    .t_data  (t_data),
    .t_last  (t_last),
    .busy    (busy)
  );

`ifdef WC_TILE_IDX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      t_idx <= '0;
    end else if (t_valid && t_ready) begin
      t_idx <= t_last ? 16'd0 : t_idx + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Bench for wc_tile_feeder: directed frames plus random frames vs a tile-list model.
// Tile indices are also checked when built with WC_TILE_IDX_EN.
module tb_wc_tile_feeder;
  import wc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [9:0]  s_data;
  logic        s_last;
  logic        t_valid;
  logic        t_ready;
  logic [69:0] t_data;
  logic        t_last;
`ifdef WC_TILE_IDX_EN
  logic [15:0] t_idx;
`endif

  typedef struct {
    logic [69:0] d;
    bit          last;
    int          idx;
  } tile_t;

  tile_t exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int low_cnt = 0;
  int rdy_mode = 0;

  wc_tile_feeder dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .t_valid (t_valid),
    .t_ready (t_ready),
    .t_data  (t_data),
    .t_last  (t_last)
`ifdef WC_TILE_IDX_EN
    ,
    .t_idx   (t_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Frame of n samples -> tiles of 7 taken every 3 samples, zero-padded.
  function automatic void model(input logic [9:0] v[$]);
    int n = v.size();
    int k = (((n - 4) > 1 ? (n - 4) : 1) + 2) / 3;
    logic [9:0] p[$] = v;
    tile_t t;
    while (p.size() < 7 + 3 * (k - 1)) p.push_back(10'd0);
    for (int i = 0; i < k; i++) begin
      t.d = '0;
      for (int j = 0; j < 7; j++) t.d = {t.d[59:0], p[3*i+j]};
      t.last = (i == k - 1);
      t.idx  = i;
      exp_q.push_back(t);
    end
  endfunction

  initial begin
    t_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: t_ready = 1'b1;
        1: t_ready = 1'($urandom);
        default: t_ready = 1'b0;
      endcase
    end
  end

  tile_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (!s_ready) low_cnt++;
      if (t_valid && t_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_tile", 80'(t_data), 80'd0);
        end else begin
          e = exp_q.pop_front();
          check("tile_data", 80'(t_data), 80'(e.d));
          check("tile_last", 80'(t_last), 80'(e.last));
`ifdef WC_TILE_IDX_EN
          check("tile_idx", 80'(t_idx), 80'(e.idx));
`endif
        end
      end
    end
  end

  task automatic send(input logic [9:0] v[$], input bit last,
                      input bit gaps);
    bit acc;
    foreach (v[i]) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      s_valid = 1'b1;
      s_data  = v[i];
      s_last  = last && (i == v.size() - 1);
      acc = 1'b0;
      for (int c = 0; c < 400 && !acc; c++) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        check("accept_timeout", 80'd0, 80'd1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 600 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check(tag, 80'(exp_q.size()), 80'd0);
  endtask

  task automatic ramp(input int first, input int n,
                      output logic [9:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(10'(first + i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] q[$];
    int vec[7] = '{2, -10, 3, 4, -13, -18, -16};
    logic [69:0] k1;
    k1 = 70'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 80'(t_valid), 80'd0);
    check("rst_last", 80'(t_last), 80'd0);
    check("rst_data", 80'(t_data), 80'd0);
    check("rst_ready", 80'(s_ready), 80'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    q = {};
    foreach (vec[i]) q.push_back(vec[i][9:0]);
    model(q);
    send(q, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_valid", 80'(t_valid), 80'd1);
    check("lat_data", 80'(t_data), 80'(k1));
    check("lat_last", 80'(t_last), 80'd1);
    @(posedge clk);
    #1;
    drain("drain_vec");

    ramp(1, 10, q);
    low_cnt = 0;
    model(q);
    send(q, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("pad_n10", 80'(low_cnt), 80'd0);
    drain("drain_n10");

    ramp(1, 11, q);
    low_cnt = 0;
    model(q);
    send(q, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("pad_n11", 80'(low_cnt), 80'd2);
    drain("drain_n11");

    rdy_mode = 2;
    @(posedge clk);
    #1;
    ramp(1, 10, q);
    model(q);
    fork
      send(q, 1'b1, 1'b0);
      begin
        repeat (25) @(negedge clk);
        check("stall_ready", 80'(s_ready), 80'd0);
        check("stall_valid", 80'(t_valid), 80'd1);
        check("stall_data", 80'(t_data), 80'(exp_q[0].d));
        repeat (3) @(negedge clk);
        check("hold_data", 80'(t_data), 80'(exp_q[0].d));
        check("hold_last", 80'(t_last), 80'd0);
        rdy_mode = 0;
      end
    join
    drain("drain_stall");

    ramp(300, 5, q);
    send(q, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 80'(t_valid), 80'd0);
    @(posedge clk);
    #1;
    ramp(400, 7, q);
    model(q);
    send(q, 1'b1, 1'b0);
    drain("drain_rst");

    ramp(20, 16, q);
    model(q);
    send(q, 1'b1, 1'b0);
    ramp(50, 3, q);
    model(q);
    send(q, 1'b1, 1'b0);
    drain("drain_idx");

    rdy_mode = 1;
    for (int f = 0; f < 15; f++) begin
      q = {};
      repeat ($urandom_range(1, 20)) q.push_back(10'($urandom));
      model(q);
      send(q, 1'b1, 1'b1);
    end
    drain("drain_rand");
    rdy_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wc_tile_feeder.md
Name: wc_tile_feeder

Overview:
- Stream-to-tile front end for the F(3,5) Winograd convolution core (WC).
- Accepts one signed 10-bit sample per handshake and builds overlapping 7-sample tiles with a stride of 3 (4-sample overlap).
- Presents each tile as the core's 70-bit D word on a valid/ready interface.
- At end of frame, zero-pads the last partial tile so every valid convolution output is covered.

Parameters:
- DW, 10, sample width in bits (two's complement).
- TILE, 7, samples per tile (m+r-1 for F(3,5)).
- STRIDE, 3, new samples per tile after the first (m).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  feeder accepts a sample this cycle.
- s_data  in  DW  signed sample.
- s_last  in  1  marks the final sample of the frame.
- t_valid  out  1  tile valid.
- t_ready  in  1  downstream (WC issue logic) accepts the tile.
- t_data  out  TILE*DW  tile. Oldest sample in [69:60], newest in [9:0] (same packing as WC.D).
- t_last  out  1  final tile of the frame.

Behaviour:
- Reset (synchronous, active-high):
  - t_valid=0, t_last=0, t_data=0.
  - Window cleared, need=TILE, state=FILL.
  - rst mid-frame discards the partial window and any held tile.
- Window:
  - TILE x DW shift register. Each accepted sample (or pad zero) shifts in at the newest end.
  - need counts the samples still missing for the next tile.
- States:
  - FILL: need starts at 7. When it reaches 0, go to STRIDE with need=3.
  - STRIDE: collect 3 samples per tile.
  - PAD: entered when s_last is accepted and need after that accept is >0. s_ready=0; one zero is shifted in per cycle until need=0.
  - After the tile completed by s_last or by padding is loaded: return to FILL, need=7, window cleared.
- Tile load:
  - On the edge where need becomes 0, the next-window value loads into the output register.
  - t_valid rises the next cycle (latency 1 cycle from the completing sample).
  - t_last is set if that tile closes the frame.
- Stall:
  - Output register is busy when t_valid && !t_ready.
  - When need==1 and the output register is busy: s_ready=0, or PAD holds (no zero shifted).
  - Otherwise s_ready=1 outside PAD.
  - Back-to-back: a load and a drain in the same cycle is allowed, with no bubble.
- Hold: t_data and t_last stay stable while t_valid && !t_ready.
- Frame sizing:
  - A frame of N samples yields ceil(max(N-4,1)/3) tiles.
  - Example: N=7 gives 1 tile, N=10 gives 2, N=11 gives 3 (the last tile has 2 zero pads).
  - N<7 gives one tile padded to 7.
- s_last on a sample that completes a tile exactly: no padding, t_last=1 on that tile.
- s_valid=0 while collecting: no state change.
- Data is passed through bit-exact; no arithmetic is done on samples.

Optional Feature:
- WC_TILE_IDX_EN defined:
  - Adds output t_idx[15:0], the tile index within the frame.
  - 0 on the first tile; increments on each t_valid&&t_ready; cleared after the t_last handshake and on rst.
  - Wraps at 65535 to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package wc_pkg holds:
  - constants WC_DW=10, WC_M=3, WC_R=5, WC_TILE=WC_M+WC_R-1;
  - the sample_t typedef (signed DW);
  - the state enum {FILL, STRIDE, PAD}.
- One natural sub-module: wc_tile_skid, the single-entry output holding register with valid/ready and hold logic.
- The window/counter/FSM stays in the top.

Test Plan:
- Stream 2,-10,3,4,-13,-18,-16 with s_last on -16, t_ready=1:
  - one tile with t_data=70'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000, t_last=1;
  - t_valid exactly 1 cycle after the -16 accept.
- Stream 10 samples 1..10, last on 10:
  - tiles {1..7} and {4..10} (t_last only on the second);
  - no padding cycles.
- Stream 11 samples 1..11:
  - third tile {8,9,10,11,0,0}, preceded by 7;
  - s_ready low for 2 PAD cycles, t_last=1.
- Hold t_ready=0 after the first tile, 10-sample stream:
  - s_ready drops when need==1;
  - t_data unchanged across stall cycles;
  - release t_ready: second tile follows with no lost or duplicated sample.
- Assert rst for one cycle after 5 samples:
  - t_valid=0;
  - the next 7 samples form a fresh tile containing none of the earlier 5.
- With WC_TILE_IDX_EN, 16-sample frame:
  - t_idx = 0,1,2,3 on the 4 tiles;
  - the next frame restarts at 0.
